queue_reader: RTL

//  Consumer end of the message Queue: polls the queue's read side and drains one message at a time.
//  The queue's read_en/read outputs are registered, so the answer to a request arrives the next cycle.

---
 rtl/queue_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/queue_reader.sv
// queue_reader: consumer end of the message queue. Issues one-cycle read
// requests, captures the queue's answer one cycle later, holds the message
// for a valid/ready handoff downstream, and rate-limits empty polls with a
// backoff counter. Delivered messages and empty polls are counted (saturating).
module queue_reader #(
    parameter int msg_width = 8,
    parameter int backoff   = 4,
    parameter int cnt_width = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [msg_width-1:0] q_read,
    input  logic                 q_read_en,
    output logic                 q_read_ack,
    output logic [msg_width-1:0] out_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [cnt_width-1:0] msg_count,
    output logic [cnt_width-1:0] empty_count,
    output logic                 stray_err
);

    localparam int CTR_W = (backoff > 1) ? $clog2(backoff) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(backoff - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_BACKOFF = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic                 ack_q, ack_d;
    logic [msg_width-1:0] out_msg_q, out_msg_d;
    logic                 out_valid_q, out_valid_d;
    logic [cnt_width-1:0] msg_count_q, msg_count_d;
    logic [cnt_width-1:0] empty_count_q, empty_count_d;
    logic                 stray_q, stray_d;

    // Next-state, datapath and counter logic for the poll/hold/backoff FSM
    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        out_msg_d     = out_msg_q;
        out_valid_d   = out_valid_q;
        msg_count_d   = msg_count_q;
        empty_count_d = empty_count_q;
        stray_d       = stray_q | (q_read_en && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (q_read_en) begin
                    out_msg_d   = q_read;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    if (empty_count_q != '1) begin
                        empty_count_d = empty_count_q + cnt_width'(1);
                    end
                    ctr_d   = CTR_LOAD;
                    state_d = ST_BACKOFF;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (msg_count_q != '1) begin
                        msg_count_d = msg_count_q + cnt_width'(1);
                    end
                    state_d = enable ? ST_REQ : ST_IDLE;
                end
            end
            ST_BACKOFF: begin
                if (ctr_q == '0) begin
                    state_d = enable ? ST_REQ : ST_IDLE;
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Request is registered from the next state so it is high exactly
        // while the FSM sits in REQ.
        ack_d = (state_d == ST_REQ);
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ctr_q         <= '0;
            ack_q         <= 1'b0;
            out_msg_q     <= '0;
            out_valid_q   <= 1'b0;
            msg_count_q   <= '0;
            empty_count_q <= '0;
            stray_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            ack_q         <= ack_d;
            out_msg_q     <= out_msg_d;
            out_valid_q   <= out_valid_d;
            msg_count_q   <= msg_count_d;
            empty_count_q <= empty_count_d;
            stray_q       <= stray_d;
        end
    end

    assign q_read_ack  = ack_q;
    assign out_msg     = out_msg_q;
    assign out_valid   = out_valid_q;
    assign msg_count   = msg_count_q;
    assign empty_count = empty_count_q;
    assign stray_err   = stray_q;

endmodule
